// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - multi-cycle restoring divider sequencer for DIV/DIVU
module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'd32;

  state_t      state;
  logic [5:0]  cnt;
  // Partial remainder is always below the divisor after a step, so 32 bits
  // hold it; the extra top bit only exists transiently in the trial value.
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        neg_dividend;
  logic        neg_divisor;

  logic [31:0] abs_op1;
  logic [31:0] abs_op2;
  logic        op1_neg;
  logic        op2_neg;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] diff;
  logic [31:0] final_quo;
  logic [31:0] final_rem;

  // Operand magnitudes and sign flags for the start cycle (signed mode only)
  always_comb begin
    op1_neg = signed_div_i & opdata1_i[31];
    op2_neg = signed_div_i & opdata2_i[31];
    abs_op1 = op1_neg ? (32'd0 - opdata1_i) : opdata1_i;
    abs_op2 = op2_neg ? (32'd0 - opdata2_i) : opdata2_i;
  end

  // One restoring shift-subtract step: shift the next dividend bit into the
  // remainder and subtract the divisor if it fits. When it fits, the true
  // difference is below the divisor, so a 32-bit wrapping subtract is exact.
  always_comb begin
    trial = {rem, quo[31]};
    fits  = (trial >= {1'b0, dvs});
    diff  = trial[31:0] - dvs;
  end

  // Sign correction of the finished magnitudes: quotient follows the XOR of
  // the signs, remainder follows the dividend.
  always_comb begin
    final_quo = (neg_dividend ^ neg_divisor) ? (32'd0 - quo) : quo;
    final_rem = neg_dividend ? (32'd0 - rem) : rem;
  end

  // Stall request: raised in the request cycle itself so the pipeline
  // freezes before the divider has registered anything.
  always_comb begin
    busy_o = (state == ST_ON) || (state == ST_BYZERO) ||
             ((state == ST_FREE) && start_i && !annul_i);
  end

  // Sequencer FSM with registered result and ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FREE;
      cnt          <= 6'd0;
      rem          <= 32'd0;
      quo          <= 32'd0;
      dvs          <= 32'd0;
      neg_dividend <= 1'b0;
      neg_divisor  <= 1'b0;
      result_o     <= 64'd0;
      ready_o      <= 1'b0;
    end else begin
      case (state)
        ST_FREE: begin
          result_o <= 64'd0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= ST_BYZERO;
            end else begin
              state        <= ST_ON;
              dvs          <= abs_op2;
              quo          <= abs_op1;
              rem          <= 32'd0;
              cnt          <= 6'd0;
              neg_dividend <= op1_neg;
              neg_divisor  <= op2_neg;
            end
          end
        end

        ST_BYZERO: begin
          result_o <= 64'd0;
          if (annul_i) begin
            state   <= ST_FREE;
            ready_o <= 1'b0;
          end else begin
            state   <= ST_END;
            ready_o <= 1'b1;
          end
        end

        ST_ON: begin
          if (annul_i) begin
            state    <= ST_FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end else if (cnt != LAST_STEP) begin
            rem <= fits ? diff : trial[31:0];
            quo <= {quo[30:0], fits};
            cnt <= cnt + 6'd1;
          end else begin
            state    <= ST_END;
            result_o <= {final_rem, final_quo};
            ready_o  <= 1'b1;
          end
        end

        ST_END: begin
          // Annul is deliberately ignored here: the result is already final.
          if (!start_i) begin
            state    <= ST_FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end

        default: begin
          state    <= ST_FREE;
          result_o <= 64'd0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int errors;
  int checks;

  div_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
    end
  endtask

  // Full transaction: request, operand scramble after sampling, latency,
  // result, hold in END (with annul ignored), release.
  task automatic do_div(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat;
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    #1;
    check({name, " busy_req"}, {63'd0, busy_o}, 64'd1);
    @(posedge clk);
    #1;
    signed_div_i = ~sgn;
    opdata1_i    = ~a;
    opdata2_i    = ~b;
    lat = 0;
    while (!ready_o && lat < 40) begin
      if (result_o !== 64'd0 || busy_o !== 1'b1) bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " run_outputs"}, {63'd0, bad}, 64'd0);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, result_o, exp);
    check({name, " busy_end"}, {63'd0, busy_o}, 64'd0);
    @(negedge clk);
    annul_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check({name, " hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check({name, " release"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  initial begin
    int wait_ready;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    start_i = 1'b0;
    annul_i = 1'b0;

    vecs[0]  = '{"divu_100_7",   1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33};
    vecs[1]  = '{"div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2]  = '{"div_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
    vecs[3]  = '{"divu_by_zero", 1'b0, 32'hFFFFFFFF, 32'd0,        64'h0,                 1};
    vecs[4]  = '{"div_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33};
    vecs[5]  = '{"divu_ovf_ops", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33};
    vecs[6]  = '{"divu_9_3",     1'b0, 32'd9,        32'd3,        64'h00000000_00000003, 33};
    vecs[7]  = '{"divu_0_5",     1'b0, 32'd0,        32'd5,        64'h0,                 33};
    vecs[8]  = '{"divu_5_7",     1'b0, 32'd5,        32'd7,        64'h00000005_00000000, 33};
    vecs[9]  = '{"divu_max_1",   1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33};
    vecs[10] = '{"div_m100_m7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33};
    vecs[11] = '{"div_by_zero",  1'b1, 32'd5,        32'd0,        64'h0,                 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {ready_o, busy_o, result_o[61:0]}, 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    // Annul at step 10: no result ever presented, then a clean 9/3
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_free", {62'd0, ready_o, busy_o} | result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    wait_ready = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ready_o) wait_ready++;
    end
    check("annul_no_ready", 64'(wait_ready), 64'd0);
    do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Annul has priority over start in FREE
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    annul_i = 1'b1;
    #1;
    check("annul_prio_busy", {63'd0, busy_o}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    @(posedge clk);
    #1;
    check("annul_prio_idle", {62'd0, ready_o, busy_o}, 64'd0);

    // Reset at step 20 aborts the division
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_outputs", {62'd0, ready_o, busy_o} | result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (ready_o) wait_ready++;
    end
    check("midrst_no_ready", 64'(wait_ready), 64'd0);
    do_div("after_rst_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the DIV/DIVU instructions, sitting beside the execute stage. The execute stage raises a start request with both operands and holds it. This block latches the operands, runs a 32-step restoring shift-subtract division, and returns a 64-bit {remainder, quotient} result with a ready flag. The execute stage writes that result to HI/LO; `busy_o` feeds the pipeline stall controller.

## Interface
- No parameters; data width fixed at 32 bits (`RegBus`), result 64 bits (`DoubleRegBus`).
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous reset, active-high (`RstEnable` = 1'b1)
- `signed_div_i`  in  1  1 = signed DIV, 0 = unsigned DIVU; sampled with start
- `opdata1_i`  in  32  dividend; sampled with start
- `opdata2_i`  in  32  divisor; sampled with start
- `start_i`  in  1  division request; held high by execute until ready_o seen
- `annul_i`  in  1  cancel in-flight division (flush/exception)
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}; valid while ready_o=1, else 0
- `ready_o`  out  1  result valid
- `busy_o`  out  1  division in progress; drives stall request

## Operation
- States: FREE, BYZERO, ON, END; 6-bit step counter `cnt`; 33-bit partial remainder R; 32-bit quotient shifter Q; 32-bit divisor D; sign flags.
- FREE: `ready_o`=0, `result_o`=0.
  - If `start_i`=1, `annul_i`=0, `opdata2_i`=0 → BYZERO.
  - If `start_i`=1, `annul_i`=0, `opdata2_i`≠0 → ON:
    - latch D=|opdata2| and Q=|opdata1| (magnitudes only when signed and the operand MSB=1; two's-complement negate);
    - R=0, cnt=0;
    - latch sign of the dividend and sign of the divisor (signed mode only; both 0 for DIVU).
- ON, one step per cycle while cnt<32:
  - T = {R[31:0], Q[31]};
  - if T ≥ {1'b0, D}: R=T−D and shift 1 into Q LSB; else R=T and shift 0 in;
  - cnt+1.
- ON with cnt=32:
  - quotient = Q, negated if the two latched signs differ;
  - remainder = R[31:0], negated if the dividend sign is 1;
  - register into `result_o`, `ready_o`=1 → END.
- BYZERO: next edge → END with `result_o`=0, `ready_o`=1.
- END: hold `result_o` and `ready_o`=1 while `start_i`=1. When `start_i`=0 → FREE, outputs cleared.
- `annul_i`=1 in ON or BYZERO → FREE next edge, `result_o`=0, `ready_o`=0, no result ever presented. In FREE, annul has priority over start. In END, annul is ignored.
- Operand inputs after the start edge are ignored; the latched values are used throughout.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): magnitude quotient 0x80000000, signs equal, no negation → Q=0x80000000, R=0. No trap.
- `busy_o` = (state==ON) | (state==BYZERO) | (state==FREE & start_i & !annul_i). It is combinational from state and inputs, so the stall asserts in the same cycle as the request.

## Timing
- Reset: state=FREE, cnt=0, R/Q/D=0, `result_o`=0, `ready_o`=0; `busy_o`=0 unless start is held during reset release. Reset mid-division aborts with no result.
- Normal latency: start sampled at edge k → ON; steps at edges k+1..k+32; edge k+33 → END. `ready_o` is high from edge k+33, so 33 cycles after the sampling edge, 34 cycles including the request cycle.
- Divide-by-zero latency: start at edge k → BYZERO; edge k+1 → END, `ready_o`=1.
- Back-to-back: a new division cannot start until one cycle with `start_i`=0 returns the FSM to FREE. Minimum issue gap between ready and the next sampled start is 1 cycle.
- `ready_o` is a registered output; it drops on the edge where `start_i`=0 is seen in END.

## Test plan
- DIVU 100/7: start held → at edge k+33, `result_o`=0x00000002_0000000E, `ready_o`=1; drop start → next edge `ready_o`=0, `result_o`=0.
- DIV −7/2 (0xFFFFFFF9, 0x00000002) → `result_o`=0xFFFFFFFF_FFFFFFFD; DIV 7/−2 → 0x00000001_FFFFFFFD.
- DIVU 0xFFFFFFFF/0 → BYZERO, `ready_o`=1 at edge k+1, `result_o`=0; `busy_o`=1 only in request and BYZERO cycles.
- DIV 0x80000000/0xFFFFFFFF → `result_o`=0x00000000_80000000; DIVU same operands → 0x80000000_00000000.
- Start DIVU 1000/3, assert `annul_i` at step 10 → FREE next edge, `ready_o` never asserts. Then start 9/3 → `result_o`=0x00000000_00000003 after 33 edges.
- Assert `rst` at step 20 → all outputs 0 next edge; change operands mid-division → result unaffected.
